// File: rtl/exec_stage_pipe.sv
// Registered RV32-style execute stage: operand mux, ALU decode, ALU, branch resolve and target adder.
// Define EXEC_MUL_EN to add an iterative shift-add multiplier (MUL) that stalls upstream for XLEN cycles.
module exec_stage_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            alusrc,
    input  logic [2:0]      funct3,
    input  logic            funct7_30,
    input  logic            funct7_25,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            br_taken,
    output logic [XLEN-1:0] target
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] tgt_sum;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic            br_res;
    logic            accept;

    logic            valid_q,  valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q,   zero_d;
    logic            br_q,     br_d;
    logic [XLEN-1:0] target_q, target_d;

`ifdef EXEC_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q,   cnt_d;
    logic [XLEN-1:0] acc_q,   acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_step;
    logic            is_mul;

    assign is_mul   = (alu_op == 2'b10) && funct7_25 && (funct3 == 3'b000);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
`else
    logic unused_funct7_25;
    assign unused_funct7_25 = funct7_25;
    assign in_ready = !valid_q || out_ready;
`endif

    assign op_b    = alusrc ? imm : rd2;
    assign shamt   = op_b[SHW-1:0];
    assign lt_s    = $signed(rd1) < $signed(op_b);
    assign lt_u    = rd1 < op_b;
    assign eq      = rd1 == op_b;
    assign tgt_sum = pc + imm;
    assign accept  = in_valid && in_ready && !flush;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00: alu_res = rd1 + op_b;
            2'b01: alu_res = rd1 - op_b;
            default: begin
                case (funct3)
                    // Only R-type honours bit 30 as SUB; for I-type it is part of the immediate.
                    3'b000: alu_res = (alu_op == 2'b10 && funct7_30) ? rd1 - op_b : rd1 + op_b;
                    3'b001: alu_res = rd1 << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
                    3'b100: alu_res = rd1 ^ op_b;
                    3'b101: alu_res = funct7_30 ? $unsigned($signed(rd1) >>> shamt) : rd1 >> shamt;
                    3'b110: alu_res = rd1 | op_b;
                    default: alu_res = rd1 & op_b;
                endcase
            end
        endcase
    end

    always_comb begin
        br_res = 1'b0;
        if (alu_op == 2'b01) begin
            case (funct3)
                3'b000:  br_res = eq;
                3'b001:  br_res = !eq;
                3'b100:  br_res = lt_s;
                3'b101:  br_res = !lt_s;
                3'b110:  br_res = lt_u;
                3'b111:  br_res = !lt_u;
                default: br_res = 1'b0;
            endcase
        end
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        br_d     = br_q;
        target_d = target_q;
`ifdef EXEC_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
`ifdef EXEC_MUL_EN
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                result_d = acc_step;
                zero_d   = (acc_step == '0);
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (accept && is_mul) begin
            state_d  = S_MUL;
            cnt_d    = SHW'(XLEN - 1);
            acc_d    = '0;
            mcand_d  = rd1;
            mplier_d = rd2;
            valid_d  = 1'b0;
            br_d     = 1'b0;
            target_d = tgt_sum;
`endif
        end else if (accept) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            br_d     = br_res;
            target_d = tgt_sum;
            valid_d  = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            br_q     <= 1'b0;
            target_q <= '0;
`ifdef EXEC_MUL_EN
            state_q  <= S_IDLE;
            cnt_q    <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            br_q     <= br_d;
            target_q <= target_d;
`ifdef EXEC_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

`ifdef EXEC_MUL_EN
    // Multiplier datapath is qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end
`endif

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign br_taken  = br_q;
    assign target    = target_q;

endmodule
